// File: rtl/wb_lsu_master.sv
// wb_lsu_master: single-outstanding load/store unit driving a Wishbone classic master port.
// Optional ack timeout is enabled by defining WB_LSU_TIMEOUT_EN.
`default_nettype none

module wb_lsu_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [31:0]           wb_dat_o,
  output logic [3:0]            wb_sel_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [31:0]           r_wdata;
  logic                  r_err;
  logic [31:0]           r_rdata;
  logic                  w_misaligned;
  logic                  w_timeout;
  logic [31:0]           w_load_ext;

  always_comb begin
    w_misaligned = 1'b0;
    case (req_size_i)
      SZ_BYTE: w_misaligned = 1'b0;
      SZ_HALF: w_misaligned = req_addr_i[0];
      SZ_WORD: w_misaligned = (req_addr_i[1:0] != 2'b00);
      default: w_misaligned = 1'b1;
    endcase
  end

`ifdef WB_LSU_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tcnt;

  // Counter reads 0 in the first BUS cycle, so the drop lands after exactly TIMEOUT_CYCLES BUS cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i || r_state != S_BUS) r_tcnt <= '0;
    else                           r_tcnt <= r_tcnt + 1'b1;
  end

  assign w_timeout = (r_state == S_BUS) && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Lane select and sign/zero extension of the returning load data.
  always_comb begin
    logic [7:0]  w_b;
    logic [15:0] w_h;
    w_b = 8'h00;
    w_h = 16'h0000;
    w_load_ext = 32'h0;
    case (r_addr[1:0])
      2'd0:    w_b = wb_dat_i[7:0];
      2'd1:    w_b = wb_dat_i[15:8];
      2'd2:    w_b = wb_dat_i[23:16];
      default: w_b = wb_dat_i[31:24];
    endcase
    w_h = r_addr[1] ? wb_dat_i[31:16] : wb_dat_i[15:0];
    case (r_size)
      SZ_BYTE: w_load_ext = {{24{~r_unsigned & w_b[7]}}, w_b};
      SZ_HALF: w_load_ext = {{16{~r_unsigned & w_h[15]}}, w_h};
      default: w_load_ext = wb_dat_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid_i) w_next = w_misaligned ? S_RESP : S_BUS;
      S_BUS:  if (wb_ack_i || wb_err_i || w_timeout) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_wdata    <= 32'h0;
      r_err      <= 1'b0;
      r_rdata    <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_we       <= req_we_i;
            r_addr     <= req_addr_i;
            r_size     <= req_size_i;
            r_unsigned <= req_unsigned_i;
            r_wdata    <= req_wdata_i;
            r_err      <= w_misaligned;
            r_rdata    <= 32'h0;
          end
        end
        S_BUS: begin
          if (wb_err_i) begin
            r_err   <= 1'b1;
            r_rdata <= 32'h0;
          end else if (wb_ack_i) begin
            r_err   <= 1'b0;
            r_rdata <= r_we ? 32'h0 : w_load_ext;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus outputs are qualified by BUS so they read 0 in every other state.
  always_comb begin
    req_ready_o = (r_state == S_IDLE);
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    rsp_rdata_o = 32'h0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_we_o     = 1'b0;
    wb_adr_o    = '0;
    wb_dat_o    = 32'h0;
    wb_sel_o    = 4'b0000;
    if (r_state == S_RESP) begin
      rsp_valid_o = 1'b1;
      rsp_err_o   = r_err;
      rsp_rdata_o = r_rdata;
    end
    if (r_state == S_BUS) begin
      wb_cyc_o = 1'b1;
      wb_stb_o = 1'b1;
      wb_we_o  = r_we;
      wb_adr_o = {r_addr[ADDR_WIDTH-1:2], 2'b00};
      case (r_size)
        SZ_BYTE: begin
          wb_sel_o = 4'b0001 << r_addr[1:0];
          wb_dat_o = {4{r_wdata[7:0]}};
        end
        SZ_HALF: begin
          wb_sel_o = r_addr[1] ? 4'b1100 : 4'b0011;
          wb_dat_o = {2{r_wdata[15:0]}};
        end
        default: begin
          wb_sel_o = 4'b1111;
          wb_dat_o = r_wdata;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_lsu_master.sv
// Directed self-checking bench for wb_lsu_master.
`default_nettype none

module tb_wb_lsu_master;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = 32'h0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;

  int checks = 0;
  int errors = 0;

  wb_lsu_master #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr;
    req_size_i = size; req_unsigned_i = uns; req_wdata_i = wdata;
    tick();
    req_valid_i = 1'b0;
  endtask

  // One zero-wait-state ack cycle: call in the first BUS cycle.
  task automatic ack_now(input logic [31:0] data);
    wb_dat_i = data; wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
  endtask

  initial begin
    // Reset state
    rst_i = 1'b1;
    tick();
    chk("rst_ready", {31'b0, req_ready_o}, 32'd1);
    chk("rst_cyc", {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("rst_rsp", {31'b0, rsp_valid_o}, 32'd0);
    chk("rst_bus", wb_adr_o | wb_dat_o | {28'b0, wb_sel_o} | rsp_rdata_o, 32'd0);
    rst_i = 1'b0;
    tick();

    // Word load 0x10, zero wait states
    issue(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    chk("wl_cyc", {30'b0, wb_cyc_o, wb_stb_o}, 32'd3);
    chk("wl_sel", {28'b0, wb_sel_o}, 32'hF);
    chk("wl_adr", wb_adr_o, 32'h10);
    chk("wl_we", {31'b0, wb_we_o}, 32'd0);
    chk("wl_ready_busy", {31'b0, req_ready_o}, 32'd0);
    ack_now(32'hDEADBEEF);
    chk("wl_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("wl_rdata", rsp_rdata_o, 32'hDEADBEEF);
    chk("wl_err", {31'b0, rsp_err_o}, 32'd0);
    chk("wl_cyc_drop", {31'b0, wb_cyc_o}, 32'd0);
    tick();
    chk("wl_valid_once", {31'b0, rsp_valid_o}, 32'd0);
    chk("wl_ready_back", {31'b0, req_ready_o}, 32'd1);

    // Signed and unsigned byte loads from 0x13
    issue(1'b0, 32'h13, 2'b00, 1'b0, 32'h0);
    chk("bs_sel", {28'b0, wb_sel_o}, 32'h8);
    chk("bs_adr", wb_adr_o, 32'h10);
    ack_now(32'h80123456);
    chk("bs_rdata", rsp_rdata_o, 32'hFFFFFF80);
    tick();
    issue(1'b0, 32'h13, 2'b00, 1'b1, 32'h0);
    ack_now(32'h80123456);
    chk("bu_rdata", rsp_rdata_o, 32'h00000080);
    tick();

    // Signed half load from 0x02 and byte load from lane 1
    issue(1'b0, 32'h02, 2'b01, 1'b0, 32'h0);
    chk("hl_sel", {28'b0, wb_sel_o}, 32'hC);
    ack_now(32'h9ABC1234);
    chk("hl_rdata", rsp_rdata_o, 32'hFFFF9ABC);
    tick();
    issue(1'b0, 32'h101, 2'b00, 1'b0, 32'h0);
    chk("b1_sel", {28'b0, wb_sel_o}, 32'h2);
    ack_now(32'h00007F00);
    chk("b1_rdata", rsp_rdata_o, 32'h0000007F);
    tick();

    // Half store 0x22
    issue(1'b1, 32'h22, 2'b01, 1'b0, 32'h0000ABCD);
    chk("hs_sel", {28'b0, wb_sel_o}, 32'hC);
    chk("hs_dat", wb_dat_o, 32'hABCDABCD);
    chk("hs_we", {31'b0, wb_we_o}, 32'd1);
    chk("hs_adr", wb_adr_o, 32'h20);
    ack_now(32'h12345678);
    chk("hs_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("hs_rdata", rsp_rdata_o, 32'h0);
    tick();

    // Byte store replicates across lanes
    issue(1'b1, 32'h31, 2'b00, 1'b0, 32'h000000A5);
    chk("bst_dat", wb_dat_o, 32'hA5A5A5A5);
    chk("bst_sel", {28'b0, wb_sel_o}, 32'h2);
    ack_now(32'h0);
    tick();

    // Misaligned word load 0x05
    issue(1'b0, 32'h05, 2'b10, 1'b0, 32'h0);
    chk("mis_cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("mis_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("mis_err", {31'b0, rsp_err_o}, 32'd1);
    chk("mis_rdata", rsp_rdata_o, 32'h0);
    tick();
    chk("mis_ready", {31'b0, req_ready_o}, 32'd1);

    // Size 11 is illegal
    issue(1'b0, 32'h08, 2'b11, 1'b0, 32'h0);
    chk("sz3_err", {30'b0, wb_cyc_o, rsp_err_o}, 32'd1);
    tick();

    // Slave err after 3 wait states (ack also high: err wins); request inputs churn meanwhile
    issue(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
    req_addr_i = 32'hFFFF_FFF0; req_we_i = 1'b1; req_size_i = 2'b00;
    for (int i = 0; i < 3; i++) begin
      chk("we_hold_adr", wb_adr_o, 32'h40);
      chk("we_hold_ctl", {26'b0, wb_cyc_o, wb_stb_o, wb_we_o, 1'b0, rsp_valid_o, req_ready_o}, 32'h30);
      tick();
    end
    chk("we_hold_sel4", {28'b0, wb_sel_o}, 32'hF);
    wb_err_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'h11223344;
    tick();
    wb_err_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    chk("we_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("we_err", {31'b0, rsp_err_o}, 32'd1);
    chk("we_rdata", rsp_rdata_o, 32'h0);
    chk("we_cyc", {31'b0, wb_cyc_o}, 32'd0);
    tick();

    // Reset in the second BUS cycle aborts without a response
    issue(1'b0, 32'h50, 2'b10, 1'b0, 32'h0);
    tick();
    chk("ra_bus2", {31'b0, wb_cyc_o}, 32'd1);
    rst_i = 1'b1;
    wb_ack_i = 1'b1; wb_dat_i = 32'hCAFEF00D;
    tick();
    rst_i = 1'b0; wb_ack_i = 1'b0;
    chk("ra_cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("ra_ready", {31'b0, req_ready_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("ra_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
      tick();
    end

`ifdef WB_LSU_TIMEOUT_EN
    // Slave never responds: dropped after 4 BUS cycles, late ack ignored
    issue(1'b0, 32'h60, 2'b10, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("to_bus", {31'b0, wb_cyc_o}, 32'd1);
      tick();
    end
    chk("to_cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("to_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("to_err", {31'b0, rsp_err_o}, 32'd1);
    wb_ack_i = 1'b1;
    tick();
    chk("to_stray_idle", {31'b0, req_ready_o}, 32'd1);
    tick();
    wb_ack_i = 1'b0;
    chk("to_stray_rsp", {30'b0, rsp_valid_o, wb_cyc_o}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/wb_lsu_master.md
WB_LSU_MASTER -- requirements
Module: wb_lsu_master

Interface
REQ-001 Parameter: ADDR_WIDTH, default 32, width of request and Wishbone addresses.
REQ-002 Parameter: TIMEOUT_CYCLES, default 255, maximum cycles to wait for ack, used only with WB_LSU_TIMEOUT_EN.
REQ-003 Port: clk_i  in  1  the only clock; all logic is rising-edge.
REQ-004 Port: rst_i  in  1  reset, synchronous and active-high.
REQ-005 Port: req_valid_i  in  1  core load/store request valid.
REQ-006 Port: req_ready_o  out  1  block can accept a request.
REQ-007 Port: req_we_i  in  1  1 = store, 0 = load.
REQ-008 Port: req_addr_i  in  ADDR_WIDTH  byte address.
REQ-009 Port: req_size_i  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-010 Port: req_unsigned_i  in  1  load zero-extends when 1 and sign-extends when 0.
REQ-011 Port: req_wdata_i  in  32  store data, right-aligned.
REQ-012 Port: rsp_valid_o  out  1  single-cycle response pulse.
REQ-013 Port: rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
REQ-014 Port: rsp_err_o  out  1  request failed, qualified by rsp_valid_o.
REQ-015 Ports: wb_cyc_o, wb_stb_o, wb_we_o (out, 1); wb_adr_o (out, ADDR_WIDTH); wb_dat_o (out, 32); wb_sel_o (out, 4). These are the Wishbone classic master outputs.
REQ-016 Ports: wb_dat_i (in, 32); wb_ack_i (in, 1); wb_err_i (in, 1). These are the Wishbone classic master inputs.

Function
REQ-017 The state machine has three states: IDLE, BUS and RESP.
REQ-018 req_ready_o is 1 only in IDLE.
REQ-019 A request is accepted when req_valid_i and req_ready_o are both 1.
REQ-020 Every request field is registered at acceptance; later input changes are ignored until the next acceptance.
REQ-021 A request is misaligned when it is a half with addr[0] = 1, a word with addr[1:0] != 0, or has size 11.
REQ-022 An aligned request goes IDLE -> BUS; in the next cycle wb_cyc_o and wb_stb_o are 1.
REQ-023 A misaligned request goes IDLE -> RESP with rsp_err_o = 1 and produces no bus cycle.
REQ-024 In BUS:
- wb_adr_o = {addr[ADDR_WIDTH-1:2], 2'b00}.
- wb_we_o = req_we.
- wb_sel_o: byte gives 1 << addr[1:0]; half gives 0011 or 1100 by addr[1]; word gives 1111.
- wb_dat_o = wdata replicated across lanes (byte x4, half x2).
REQ-025 The BUS outputs are held stable until wb_ack_i or wb_err_i is sampled at 1.
REQ-026 On ack or err in BUS, the next cycle deasserts wb_cyc_o and wb_stb_o and enters RESP; there are no back-to-back cycles.
REQ-027 wb_err_i takes priority over wb_ack_i when both are 1.
REQ-028 In RESP, rsp_valid_o is 1 for exactly one cycle, then the state returns to IDLE.
REQ-029 A load's lane is captured from wb_dat_i on ack, selected by addr[1:0] or addr[1], then extended per req_unsigned.
REQ-030 Minimum latency is acceptance at cycle 0, bus at cycle 1, ack at cycle 1, rsp_valid_o at cycle 2, and req_ready_o at cycle 3.
REQ-031 Each extra wait state adds one cycle to that latency.

Reset
REQ-032 When rst_i is sampled at 1, the state becomes IDLE and every output except req_ready_o is 0; req_ready_o is 1 since the state is IDLE.
REQ-033 A reset during BUS drops wb_cyc_o and wb_stb_o on the next edge, and no response is issued for the aborted request.
REQ-034 Reset has priority over all other events in the same cycle.

Configuration
REQ-035 With macro WB_LSU_TIMEOUT_EN defined:
- A counter clears on entry to BUS and increments each BUS cycle.
- If it reaches TIMEOUT_CYCLES without ack or err, the cycle is dropped and RESP is entered with rsp_err_o = 1.
- A later stray ack is ignored.
REQ-036 With WB_LSU_TIMEOUT_EN undefined, no counter exists and BUS waits indefinitely.

Verification
REQ-037 Word load, addr 0x10, slave returns 0xDEADBEEF with 0 wait states -> wb_sel_o = 1111, rsp_rdata_o = 0xDEADBEEF, and rsp_valid_o 2 cycles after acceptance.
REQ-038 Signed byte load, addr 0x13, wb_dat_i = 0x80123456 -> wb_sel_o = 1000 and rsp_rdata_o = 0xFFFFFF80; the unsigned load gives 0x00000080.
REQ-039 Half store, addr 0x22, wdata 0x0000ABCD -> wb_sel_o = 1100, wb_dat_o = 0xABCDABCD, wb_we_o = 1, rsp_rdata_o = 0.
REQ-040 Word load, addr 0x05 -> no wb_cyc_o, and rsp_valid_o and rsp_err_o are 1 in the cycle after acceptance.
REQ-041 Slave asserts wb_err_i after 3 wait states -> bus outputs are held stable for 4 cycles, then rsp_err_o = 1.
REQ-042 rst_i is asserted in the second BUS cycle -> wb_cyc_o = 0 and req_ready_o = 1 on the next edge, and rsp_valid_o never pulses.
REQ-043 With WB_LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 4, a slave that never acks -> the cycle is dropped after 4 BUS cycles and rsp_err_o = 1.
